stun_controller: RTL
====================

# stun_controller

Resolves attack contacts into defender stun states for both players. It drives the 4-bit state codes that health_status consumes: 0 for none, 9 for hitstun, 10 for blockstun. The player FSMs use these codes to force S_HITSTUN / S_BLOCKSTUN, and they also feed health_status so health and guard are decremented. It sits between hitbox/hurtbox overlap detection and the player FSMs.

## Interface
- HITSTUN_FRAMES, 16, frames spent in hitstun; legal range 1..63
- BLOCKSTUN_FRAMES, 8, frames spent in blockstun; legal range 1..63
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- frame_tick  input  1  one-cycle pulse per game frame
- p1_contact  input  1  P1 attack hitbox overlaps P2 hurtbox (level)
- p2_contact  input  1  P2 attack hitbox overlaps P1 hurtbox (level)
- p1_blocking  input  1  P1 holding guard
- p2_blocking  input  1  P2 holding guard
- p1_block  input  3  P1 remaining guard, from health_status
- p2_block  input  3  P2 remaining guard, from health_status
- p1_health  input  3  P1 remaining health, from health_status
- p2_health  input  3  P2 remaining health, from health_status
- p1_stun_state  output  4  P1 stun code: 0 none, 9 hitstun, 10 blockstun
- p2_stun_state  output  4  P2 stun code, same encoding
- p1_stun_end  output  1  one-cycle pulse when P1 leaves stun
- p2_stun_end  output  1  one-cycle pulse when P2 leaves stun

## Operation
- There are two identical, independent defender channels.
  - The P1 channel is driven by p2_contact, p1_blocking, p1_block and p1_health.
  - The P2 channel is driven by p1_contact, p2_blocking, p2_block and p2_health.
- Each channel has an FSM with states IDLE, HITSTUN and BLOCKSTUN, plus a 6-bit frame counter.
- Hit event: a rising edge of the attacker's contact, against a registered copy of contact from the previous clock.
  - Only one hit is accepted per continuous contact.
  - Contact must drop for at least one clk before another hit is accepted.
- Transitions out of IDLE on a hit event:
  - health == 0: ignored; the defender is KO'd and the channel stays IDLE.
  - blocking && block != 0: go to BLOCKSTUN and load the counter with BLOCKSTUN_FRAMES.
  - blocking && block == 0 (guard break), or !blocking: go to HITSTUN and load the counter with HITSTUN_FRAMES.
- A hit event while in HITSTUN or BLOCKSTUN is ignored. There are no combos or restarts. The registered contact copy still updates.
- In HITSTUN or BLOCKSTUN, on a frame_tick:
  - counter > 1: decrement the counter.
  - counter == 1: return to IDLE, clear the counter, and pulse stun_end on the same edge.
- stun_state decodes the FSM state: IDLE = 0, HITSTUN = 9, BLOCKSTUN = 10.
- Simultaneous hits (trade): both channels enter stun on the same edge, each resolved independently.
- A hit event and a frame_tick in the same cycle while IDLE: the stun is entered with the full load. That tick is not counted.

## Timing
- Reset (rst == 0 at a clk edge), values on the next edge:
  - FSMs go to IDLE and counters go to 0.
  - stun_state = 0 and stun_end = 0.
  - The registered contact copies are set to 1, so a contact held through reset does not register as a hit.
- Reset during stun aborts it immediately. No stun_end pulse is produced.
- Latency: a contact edge at clk edge N gives stun_state valid after edge N+1.
- Stun duration is exactly FRAMES frame_ticks. IDLE is entered on the edge that samples the FRAMES-th tick after entry.
- stun_end is high for exactly one clk, coincident with stun_state returning to 0.
- Inputs are sampled synchronously and need no handshake. p*_block and p*_health are sampled on the same edge as the hit event.
- The stun_state change is seen by health_status one cycle later. The guard decrement therefore lands after this block has already decided the stun type.

## Test plan
- Reset with p1_contact held high, then release reset → no P2 stun. Drop and re-raise contact → p2_stun_state = 10 if p2_blocking with p2_block = 3, otherwise 9.
- P2 not blocking, p1_contact rises, default params → p2_stun_state = 9 one cycle later. It returns to 0 with a p2_stun_end pulse on the 16th frame_tick.
- P2 blocking, p2_block = 3 → 10 for 8 ticks. Repeat with p2_block = 0 → 9 for 16 ticks (guard break).
- Second p1_contact edge at tick 5 of hitstun → ignored; still ends at tick 16. Contact held for 40 ticks → exactly one stun.
- p1_contact and p2_contact rise on the same cycle, neither blocking → both stun states = 9 on the same edge, and both stun_end pulses on the same edge.
- p2_health = 0, then a contact edge → p2_stun_state stays 0. rst asserted at tick 4 of a stun → stun_state = 0 next edge, with no stun_end.

Source files
------------

// File: rtl/stun_controller.sv
// Stun resolution for both defenders: turns attack contacts into
// hitstun/blockstun codes and end-of-stun pulses.
module stun_channel #(
  parameter int HITSTUN_FRAMES   = 16,
  parameter int BLOCKSTUN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       contact,
  input  logic       blocking,
  input  logic [2:0] block,
  input  logic [2:0] health,
  output logic [3:0] stun_state,
  output logic       stun_end
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HITSTUN   = 4'd9,
    BLOCKSTUN = 4'd10
  } state_t;

  localparam logic [5:0] HIT_LOAD = 6'(HITSTUN_FRAMES);
  localparam logic [5:0] BLK_LOAD = 6'(BLOCKSTUN_FRAMES);

  state_t     state, state_n;
  logic [5:0] cnt, cnt_n;
  logic       contact_q;
  logic       end_n;
  logic       hit;

  assign hit        = contact & ~contact_q;
  assign stun_state = state;

  // State, counter, contact history and end pulse registers.
  // contact_q resets high so contact held through reset is not a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      contact_q <= 1'b1;
      stun_end  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      contact_q <= contact;
      stun_end  <= end_n;
    end
  end

  // Hit resolution from IDLE and frame countdown while stunned.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    end_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit && health != 3'd0) begin
          if (blocking && block != 3'd0) begin
            state_n = BLOCKSTUN;
            cnt_n   = BLK_LOAD;
          end else begin
            state_n = HITSTUN;
            cnt_n   = HIT_LOAD;
          end
        end
      end
      HITSTUN, BLOCKSTUN: begin
        if (frame_tick) begin
          if (cnt > 6'd1) begin
            cnt_n = cnt - 6'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = 6'd0;
            end_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 6'd0;
      end
    endcase
  end

endmodule

module stun_controller #(
  parameter int HITSTUN_FRAMES   = 16,
  parameter int BLOCKSTUN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       p1_contact,
  input  logic       p2_contact,
  input  logic       p1_blocking,
  input  logic       p2_blocking,
  input  logic [2:0] p1_block,
  input  logic [2:0] p2_block,
  input  logic [2:0] p1_health,
  input  logic [2:0] p2_health,
  output logic [3:0] p1_stun_state,
  output logic [3:0] p2_stun_state,
  output logic       p1_stun_end,
  output logic       p2_stun_end
);

  stun_channel #(
    .HITSTUN_FRAMES  (HITSTUN_FRAMES),
    .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES)
  ) u_p1 (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .contact   (p2_contact),
    .blocking  (p1_blocking),
    .block     (p1_block),
    .health    (p1_health),
    .stun_state(p1_stun_state),
    .stun_end  (p1_stun_end)
  );

  stun_channel #(
    .HITSTUN_FRAMES  (HITSTUN_FRAMES),
    .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES)
  ) u_p2 (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .contact   (p1_contact),
    .blocking  (p2_blocking),
    .block     (p2_block),
    .health    (p2_health),
    .stun_state(p2_stun_state),
    .stun_end  (p2_stun_end)
  );

endmodule
